// File: rtl/id_issue_stage_if.sv
// id_issue_stage_if: fetch-side, regfile, forwarding and EX-side signals of the decode stage
interface id_issue_stage_if #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int CNT_W    = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         pc_i;
  logic [31:0]               inst_i;
  logic                      flush_i;
  logic                      re1_o;
  logic                      re2_o;
  logic [REG_AW-1:0]         raddr1_o;
  logic [REG_AW-1:0]         raddr2_o;
  logic [DATA_W-1:0]         rdata1_i;
  logic [DATA_W-1:0]         rdata2_i;
  logic [NUM_FWD-1:0]        fwd_we_i;
  logic [NUM_FWD-1:0]        fwd_load_i;
  logic [NUM_FWD*REG_AW-1:0] fwd_waddr_i;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         pc_o;
  logic [ALUOP_W-1:0]        aluop_o;
  logic [ALUSEL_W-1:0]       alusel_o;
  logic [DATA_W-1:0]         op1_o;
  logic [DATA_W-1:0]         op2_o;
  logic [REG_AW-1:0]         waddr_o;
  logic                      we_o;
  logic                      mem_rd_o;
  logic                      invalid_o;
  logic [CNT_W-1:0]          stall_cnt_o;

  modport master (
    output in_valid, pc_i, inst_i, flush_i, rdata1_i, rdata2_i,
           fwd_we_i, fwd_load_i, fwd_waddr_i, fwd_wdata_i, out_ready,
    input  in_ready, re1_o, re2_o, raddr1_o, raddr2_o, out_valid, pc_o, aluop_o,
           alusel_o, op1_o, op2_o, waddr_o, we_o, mem_rd_o, invalid_o, stall_cnt_o
  );

  modport slave (
    input  in_valid, pc_i, inst_i, flush_i, rdata1_i, rdata2_i,
           fwd_we_i, fwd_load_i, fwd_waddr_i, fwd_wdata_i, out_ready,
    output in_ready, re1_o, re2_o, raddr1_o, raddr2_o, out_valid, pc_o, aluop_o,
           alusel_o, op1_o, op2_o, waddr_o, we_o, mem_rd_o, invalid_o, stall_cnt_o
  );
endinterface

// File: rtl/id_issue_stage.sv
// id_issue_stage: MIPS decode with operand forwarding, load-use stall and ID/EX register
module id_issue_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          rst,
  id_issue_stage_if.slave bus
);
  localparam logic [ALUOP_W-1:0]  EXE_NOP_OP = ALUOP_W'(8'b00000000);
  localparam logic [ALUOP_W-1:0]  EXE_AND_OP = ALUOP_W'(8'b00100100);
  localparam logic [ALUOP_W-1:0]  EXE_OR_OP  = ALUOP_W'(8'b00100101);
  localparam logic [ALUOP_W-1:0]  EXE_XOR_OP = ALUOP_W'(8'b00100110);
  localparam logic [ALUOP_W-1:0]  EXE_SLL_OP = ALUOP_W'(8'b01111100);
  localparam logic [ALUOP_W-1:0]  EXE_LW_OP  = ALUOP_W'(8'b11100011);
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP        = ALUSEL_W'(3'b000);
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC      = ALUSEL_W'(3'b001);
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT      = ALUSEL_W'(3'b010);
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOAD_STORE = ALUSEL_W'(3'b111);
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_PREF    = 6'b110011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_SYNC = 6'b001111;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sa;
  logic [15:0] imm;
  logic [1:0] re, hzp;
  logic [1:0][REG_AW-1:0] ra;
  logic [1:0][DATA_W-1:0] rdat, imm_v, fwd_v, opv;
  logic [REG_AW-1:0] waddr;
  logic we, mem_rd, inv, hz, adv, acc;
  logic [ALUOP_W-1:0] aluop;
  logic [ALUSEL_W-1:0] alusel;
  logic out_valid_q, we_q, mem_rd_q, inv_q;
  logic [DATA_W-1:0] pc_q, op1_q, op2_q;
  logic [REG_AW-1:0] waddr_q;
  logic [ALUOP_W-1:0] aluop_q;
  logic [ALUSEL_W-1:0] alusel_q;
  logic [CNT_W-1:0] cnt_q;

  assign {op, rs, rt, rd, sa, fn} = bus.inst_i;
  assign imm = bus.inst_i[15:0];
  assign ra = {REG_AW'(rt), REG_AW'(rs)};
  assign rdat = {bus.rdata2_i, bus.rdata1_i};
  assign bus.re1_o = re[0];
  assign bus.re2_o = re[1];
  assign bus.raddr1_o = ra[0];
  assign bus.raddr2_o = ra[1];

  // decode: read enables, per-port immediates, destination and EX control
  always_comb begin
    re = 2'b00;
    imm_v = '0;
    waddr = REG_AW'(rd);
    we = 1'b0;
    mem_rd = 1'b0;
    inv = 1'b1;
    aluop = EXE_NOP_OP;
    alusel = EXE_RES_NOP;
    case (op)
      OP_SPECIAL: begin
        if (fn == FN_SYNC) begin
          inv = 1'b0;
        end else if (sa == 5'd0 && (fn inside {FN_OR, FN_AND, FN_XOR, FN_NOR, FN_SLLV, FN_SRLV, FN_SRAV})) begin
          re = 2'b11;
          we = 1'b1;
          inv = 1'b0;
          aluop = ALUOP_W'({2'b00, fn});
          alusel = fn[5] ? EXE_RES_LOGIC : EXE_RES_SHIFT;
        end else if (rs == 5'd0 && (fn inside {FN_SLL, FN_SRL, FN_SRA})) begin
          re = 2'b10;
          imm_v[0] = DATA_W'(sa);
          we = 1'b1;
          inv = 1'b0;
          aluop = fn == FN_SLL ? EXE_SLL_OP : ALUOP_W'({2'b00, fn});
          alusel = EXE_RES_SHIFT;
        end
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        re = 2'b01;
        imm_v[1] = DATA_W'(imm);
        waddr = REG_AW'(rt);
        we = 1'b1;
        inv = 1'b0;
        aluop = op == OP_ORI ? EXE_OR_OP : op == OP_ANDI ? EXE_AND_OP : EXE_XOR_OP;
        alusel = EXE_RES_LOGIC;
      end
      OP_LUI: begin
        imm_v[1] = DATA_W'({imm, 16'h0000});
        waddr = REG_AW'(rt);
        we = 1'b1;
        inv = 1'b0;
        aluop = EXE_OR_OP;
        alusel = EXE_RES_LOGIC;
      end
      OP_LW: begin
        re = 2'b01;
        imm_v[1] = DATA_W'($signed(imm));
        waddr = REG_AW'(rt);
        we = 1'b1;
        mem_rd = 1'b1;
        inv = 1'b0;
        aluop = EXE_LW_OP;
        alusel = EXE_RES_LOAD_STORE;
      end
      OP_PREF: inv = 1'b0;
      default: ;
    endcase
  end

  // operand resolution: youngest matching source wins, its load flag decides the hazard
  always_comb begin
    fwd_v = rdat;
    hzp = 2'b00;
    for (int p = 0; p < 2; p++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (bus.fwd_we_i[k] && bus.fwd_waddr_i[k*REG_AW +: REG_AW] == ra[p]) begin
          fwd_v[p] = bus.fwd_wdata_i[k*DATA_W +: DATA_W];
          hzp[p] = bus.fwd_load_i[k];
        end
      end
    end
    opv[0] = !re[0] ? imm_v[0] : ra[0] == '0 ? '0 : fwd_v[0];
    opv[1] = !re[1] ? imm_v[1] : ra[1] == '0 ? '0 : fwd_v[1];
  end

  assign hz = bus.in_valid && |(hzp & re & {ra[1] != '0, ra[0] != '0});
  assign adv = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !rst && !bus.flush_i && !hz && adv;
  assign acc = bus.in_valid && bus.in_ready;

  // ID/EX register and saturating load-use stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pc_q <= '0;
      aluop_q <= EXE_NOP_OP;
      alusel_q <= EXE_RES_NOP;
      op1_q <= '0;
      op2_q <= '0;
      waddr_q <= '0;
      we_q <= 1'b0;
      mem_rd_q <= 1'b0;
      inv_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (hz && !bus.flush_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (bus.flush_i) out_valid_q <= 1'b0;
      else if (adv) begin
        out_valid_q <= acc;
        if (acc) begin
          pc_q <= bus.pc_i;
          aluop_q <= aluop;
          alusel_q <= alusel;
          op1_q <= opv[0];
          op2_q <= opv[1];
          waddr_q <= waddr;
          we_q <= we;
          mem_rd_q <= mem_rd;
          inv_q <= inv;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.pc_o = pc_q;
  assign bus.aluop_o = aluop_q;
  assign bus.alusel_o = alusel_q;
  assign bus.op1_o = op1_q;
  assign bus.op2_o = op2_q;
  assign bus.waddr_o = waddr_q;
  assign bus.we_o = we_q;
  assign bus.mem_rd_o = mem_rd_q;
  assign bus.invalid_o = inv_q;
  assign bus.stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_issue_stage.sv
// tb_id_issue_stage: directed vectors for decode, forwarding, stall, backpressure, flush and reset
module tb_id_issue_stage;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;

  id_issue_stage_if bus ();
  id_issue_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = v;
    bus.pc_i = pc;
    bus.inst_i = inst;
    #1;
  endtask

  task automatic fwd(input logic [1:0] we, input logic [1:0] ld, input logic [4:0] a1, input logic [4:0] a0,
                     input logic [31:0] d1, input logic [31:0] d0);
    bus.fwd_we_i = we;
    bus.fwd_load_i = ld;
    bus.fwd_waddr_i = {a1, a0};
    bus.fwd_wdata_i = {d1, d0};
  endtask

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.out_ready = 1'b1;
    bus.rdata1_i = 32'h1111;
    bus.rdata2_i = 32'h2222;
    fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    drive(1'b1, 32'h0, 32'h34018001);
    check("rst_in_ready", bus.in_ready, 0);
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_aluop", bus.aluop_o, 0);
    check("rst_stall", bus.stall_cnt_o, 0);
    check("rst_op1", bus.op1_o, 0);
    rst = 1'b0;
    // ori $1,$0,0x8001
    drive(1'b1, 32'h100, 32'h34018001);
    check("ori_re1", bus.re1_o, 1);
    check("ori_re2", bus.re2_o, 0);
    check("ori_in_ready", bus.in_ready, 1);
    step();
    check("ori_out_valid", bus.out_valid, 1);
    check("ori_op1", bus.op1_o, 0);
    check("ori_op2", bus.op2_o, 32'h00008001);
    check("ori_waddr", bus.waddr_o, 1);
    check("ori_we", bus.we_o, 1);
    check("ori_aluop", bus.aluop_o, 8'h25);
    check("ori_pc", bus.pc_o, 32'h100);
    // or $3,$1,$2 with both sources writing $1: youngest wins
    fwd(2'b11, 2'b00, 5'd1, 5'd1, 32'h5555, 32'hAAAA);
    drive(1'b1, 32'h104, 32'h00221825);
    check("or_raddr1", bus.raddr1_o, 1);
    check("or_raddr2", bus.raddr2_o, 2);
    step();
    check("or_fwd0_op1", bus.op1_o, 32'hAAAA);
    check("or_op2", bus.op2_o, 32'h2222);
    check("or_waddr", bus.waddr_o, 3);
    check("or_alusel", bus.alusel_o, 1);
    fwd(2'b10, 2'b00, 5'd1, 5'd1, 32'h5555, 32'hAAAA);
    drive(1'b1, 32'h108, 32'h00221825);
    step();
    check("or_fwd1_op1", bus.op1_o, 32'h5555);
    // or $3,$0,$2 with forwarding targeting $0
    fwd(2'b11, 2'b11, 5'd0, 5'd0, 32'h5555, 32'hAAAA);
    drive(1'b1, 32'h10C, 32'h00021825);
    check("r0_no_hazard", bus.in_ready, 1);
    step();
    check("r0_op1", bus.op1_o, 0);
    check("r0_op2", bus.op2_o, 32'h2222);
    // and $5,$4,$2 with lw $4 in EX
    fwd(2'b01, 2'b01, 5'd0, 5'd4, 32'h0, 32'hDEAD);
    drive(1'b1, 32'h110, 32'h00822824);
    check("hz_in_ready", bus.in_ready, 0);
    step();
    check("hz_bubble", bus.out_valid, 0);
    check("hz_stall_cnt", bus.stall_cnt_o, 1);
    fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    check("hz_release", bus.in_ready, 1);
    step();
    check("hz_out_valid", bus.out_valid, 1);
    check("hz_pc", bus.pc_o, 32'h110);
    check("hz_op1", bus.op1_o, 32'h1111);
    check("hz_aluop", bus.aluop_o, 8'h24);
    // younger non-load match masks older load
    fwd(2'b11, 2'b10, 5'd4, 5'd4, 32'hBAD, 32'h4444);
    drive(1'b1, 32'h114, 32'h00822824);
    check("mask_in_ready", bus.in_ready, 1);
    step();
    check("mask_op1", bus.op1_o, 32'h4444);
    check("mask_stall_cnt", bus.stall_cnt_o, 1);
    fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    // xori $7,$2,0xff then backpressure with lui waiting
    bus.rdata1_i = 32'h0F0F;
    drive(1'b1, 32'h118, 32'h384700FF);
    step();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11C, 32'h3C081234);
    for (int i = 0; i < 5; i++) begin
      bus.rdata1_i = 32'(i);
      #1;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_op1", bus.op1_o, 32'h0F0F);
      check("bp_op2", bus.op2_o, 32'hFF);
      check("bp_waddr", bus.waddr_o, 7);
      check("bp_pc", bus.pc_o, 32'h118);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_resume", bus.in_ready, 1);
    step();
    check("lui_out_valid", bus.out_valid, 1);
    check("lui_pc", bus.pc_o, 32'h11C);
    check("lui_op1", bus.op1_o, 0);
    check("lui_op2", bus.op2_o, 32'h12340000);
    check("lui_waddr", bus.waddr_o, 8);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("no_dup", bus.out_valid, 0);
    // invalid opcode
    drive(1'b1, 32'h120, 32'hFC000000);
    step();
    check("inv_out_valid", bus.out_valid, 1);
    check("inv_invalid", bus.invalid_o, 1);
    check("inv_we", bus.we_o, 0);
    check("inv_aluop", bus.aluop_o, 0);
    // sync
    drive(1'b1, 32'h124, 32'h0000000F);
    step();
    check("sync_invalid", bus.invalid_o, 0);
    check("sync_we", bus.we_o, 0);
    // lw $9,-4($2)
    bus.rdata1_i = 32'h0F0F;
    drive(1'b1, 32'h128, 32'h8C49FFFC);
    step();
    check("lw_op1", bus.op1_o, 32'h0F0F);
    check("lw_op2", bus.op2_o, 32'hFFFFFFFC);
    check("lw_mem_rd", bus.mem_rd_o, 1);
    check("lw_aluop", bus.aluop_o, 8'hE3);
    check("lw_alusel", bus.alusel_o, 7);
    check("lw_waddr", bus.waddr_o, 9);
    // sll $10,$3,4
    drive(1'b1, 32'h12C, 32'h00035100);
    check("sll_re1", bus.re1_o, 0);
    step();
    check("sll_op1", bus.op1_o, 4);
    check("sll_op2", bus.op2_o, 32'h2222);
    check("sll_aluop", bus.aluop_o, 8'h7C);
    check("sll_alusel", bus.alusel_o, 2);
    check("sll_mem_rd", bus.mem_rd_o, 0);
    // flush with a held instruction and a valid input
    bus.flush_i = 1'b1;
    drive(1'b1, 32'h130, 32'h34018001);
    check("flush_in_ready", bus.in_ready, 0);
    step();
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_pc_held", bus.pc_o, 32'h12C);
    bus.flush_i = 1'b0;
    // stall, stall under flush, then reset mid-stall
    fwd(2'b01, 2'b01, 5'd0, 5'd4, 32'h0, 32'h0);
    drive(1'b1, 32'h134, 32'h00822824);
    step();
    check("stall2_cnt", bus.stall_cnt_o, 2);
    bus.flush_i = 1'b1;
    step();
    check("flush_stall_cnt", bus.stall_cnt_o, 2);
    bus.flush_i = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", bus.in_ready, 0);
    step();
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_stall", bus.stall_cnt_o, 0);
    check("rst_mid_op2", bus.op2_o, 0);
    check("rst_mid_pc", bus.pc_o, 0);
    check("rst_mid_we", bus.we_o, 0);
    check("rst_mid_alusel", bus.alusel_o, 0);
    rst = 1'b0;
    fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("post_rst_idle", bus.out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
